// File: rtl/fba_adder_pipe.sv
// fba_adder_pipe: two-stage valid/ready pipelined fixed-bounding approximate adder.
// The low k bits (k programmable, 0..K) use the bounding approximation; the
// upper bits use an exact adder. k = 0 gives an exact W-bit add with carry in.
// Optional macro FBA_ERR_MON_EN adds an error monitor (err_clr_i/err_cnt_o/
// err_acc_o) that counts inexact results and accumulates |exact - approx|.
module fba_adder_pipe #(
  parameter int W     = 16,
  parameter int K     = 8,
  parameter int KW    = 4,
  parameter int ACC_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cfg_we_i,
  input  logic [KW-1:0] cfg_k_i,
  output logic [KW-1:0] cfg_k_q_o,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  logic          cin_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  y_o,
  output logic          cout_o
`ifdef FBA_ERR_MON_EN
  ,
  input  logic             err_clr_i,
  output logic [31:0]      err_cnt_o,
  output logic [ACC_W-1:0] err_acc_o
`endif
);

  logic [KW-1:0] cfg_k_q, cfg_k_d;

  logic          s1_valid_q;
  logic [W-1:0]  s1_a_q, s1_b_q;
  logic          s1_cin_q;
  logic [KW-1:0] s1_k_q;

  logic          s2_valid_q;
  logic [W-1:0]  s2_y_q;
  logic          s2_cout_q;

  logic          s1_ld, s2_ld;

  logic [W-1:0]  lo_mask;
  logic          cin_eff;
  logic [W:0]    sum_hi;
  logic [W-1:0]  both_lo;
  logic [W-1:0]  fill_lo;
  logic [W-1:0]  y_d;
  logic          cout_d;

  // Handshake: a stage loads when empty or when its content moves on.
  always_comb begin
    s2_ld      = !s2_valid_q || out_ready_i;
    s1_ld      = !s1_valid_q || s2_ld;
    in_ready_o = s1_ld;
  end

  // Configuration next value, saturated to the largest supported width.
  always_comb begin
    cfg_k_d = cfg_k_q;
    if (cfg_we_i) begin
      cfg_k_d = (cfg_k_i > KW'(K)) ? KW'(K) : cfg_k_i;
    end
  end

  // Active approximation width register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_k_q <= KW'(K);
    end else begin
      cfg_k_q <= cfg_k_d;
    end
  end

  assign cfg_k_q_o = cfg_k_q;

  // Stage 1: capture operands together with the k they were accepted under.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_k_q     <= '0;
    end else if (s1_ld) begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1_a_q   <= a_i;
        s1_b_q   <= b_i;
        s1_cin_q <= cin_i;
        s1_k_q   <= cfg_k_q;
      end
    end
  end

  // Bounding adder: exact upper field, OR/fill lower field, no carry between them.
  always_comb begin
    logic run;
    lo_mask = (W'(1) << s1_k_q) - W'(1);
    cin_eff = (s1_k_q == '0) ? s1_cin_q : 1'b0;
    sum_hi  = {1'b0, s1_a_q & ~lo_mask} + {1'b0, s1_b_q & ~lo_mask} + {{W{1'b0}}, cin_eff};
    both_lo = s1_a_q & s1_b_q & lo_mask;
    fill_lo = '0;
    run     = 1'b0;
    // Every bit at or below the highest generate position becomes 1.
    for (int j = W - 1; j >= 0; j--) begin
      run        = run | both_lo[j];
      fill_lo[j] = run;
    end
    y_d    = sum_hi[W-1:0] | ((s1_a_q | s1_b_q | fill_lo) & lo_mask);
    cout_d = sum_hi[W];
  end

  // Stage 2: result register, held while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_cout_q  <= 1'b0;
    end else if (s2_ld) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_y_q    <= y_d;
        s2_cout_q <= cout_d;
      end
    end
  end

  assign out_valid_o = s2_valid_q;
  assign y_o         = s2_y_q;
  assign cout_o      = s2_cout_q;

`ifdef FBA_ERR_MON_EN
  logic [W:0]       exact_sum;
  logic [W:0]       approx_sum;
  logic [W:0]       err_abs;
  logic [ACC_W:0]   acc_sum;
  logic [31:0]      err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0] err_acc_q, err_acc_d;

  // Error of the result entering stage 2, and saturating counter updates.
  always_comb begin
    exact_sum  = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{W{1'b0}}, cin_eff};
    approx_sum = {cout_d, y_d};
    err_abs    = (exact_sum >= approx_sum) ? (exact_sum - approx_sum)
                                           : (approx_sum - exact_sum);
    acc_sum    = {1'b0, err_acc_q} + (ACC_W+1)'(err_abs);
    err_cnt_d  = err_cnt_q;
    err_acc_d  = err_acc_q;
    if (err_clr_i) begin
      err_cnt_d = '0;
      err_acc_d = '0;
    end else if (s2_ld && s1_valid_q) begin
      if ((err_abs != '0) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 32'd1;
      end
      err_acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    end
  end

  // Monitor counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
      err_acc_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_acc_q <= err_acc_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
  assign err_acc_o = err_acc_q;
`endif

endmodule

// File: tb/tb_fba_adder_pipe.sv
// Directed bench for fba_adder_pipe. Monitor checks compile only with FBA_ERR_MON_EN.
module tb_fba_adder_pipe;
  localparam int W     = 16;
  localparam int K     = 8;
  localparam int KW    = 4;
  localparam int ACC_W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [KW-1:0] cfg_k = '0;
  logic [KW-1:0] cfg_k_q;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  y;
  logic          cout;
`ifdef FBA_ERR_MON_EN
  logic             err_clr = 1'b0;
  logic [31:0]      err_cnt;
  logic [ACC_W-1:0] err_acc;
`endif

  int errors = 0;
  int checks = 0;

  fba_adder_pipe #(.W(W), .K(K), .KW(KW), .ACC_W(ACC_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_k_i     (cfg_k),
    .cfg_k_q_o   (cfg_k_q),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .y_o         (y),
    .cout_o      (cout)
`ifdef FBA_ERR_MON_EN
    ,
    .err_clr_i   (err_clr),
    .err_cnt_o   (err_cnt),
    .err_acc_o   (err_acc)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus helpers (called at a negedge, return at a negedge).
  task automatic cfg_set(input logic [KW-1:0] v);
    cfg_we = 1'b1;
    cfg_k  = v;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

`ifdef FBA_ERR_MON_EN
  task automatic mon_clear();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask
`endif

  task automatic xact(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                      output logic [W-1:0] yv, output logic cov, output int lat);
    int n;
    a = av; b = bv; cin = cv; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
    yv  = y;
    cov = cout;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (y !== 16'h0000) begin errors++; $display("FAIL reset_y: got %h want 0000", y); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
    checks++; if (cfg_k_q !== 4'd8) begin errors++; $display("FAIL reset_cfg_k_q: got %0d want 8", cfg_k_q); end
`ifdef FBA_ERR_MON_EN
    checks++; if (err_cnt !== 32'd0 || err_acc !== '0) begin errors++; $display("FAIL reset_mon: cnt %0d acc %0d want 0 0", err_cnt, err_acc); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_exact();
    logic [W-1:0] yv; logic cov; int lat;
    cfg_set(4'd0);
    checks++; if (cfg_k_q !== 4'd0) begin errors++; $display("FAIL exact_cfg: got %0d want 0", cfg_k_q); end
`ifdef FBA_ERR_MON_EN
    mon_clear();
`endif
    xact(16'h1234, 16'h4321, 1'b1, yv, cov, lat);
    checks++; if (yv !== 16'h5556) begin errors++; $display("FAIL exact_y: got %h want 5556", yv); end
    checks++; if (cov !== 1'b0) begin errors++; $display("FAIL exact_cout: got %b want 0", cov); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL exact_latency: got %0d want 2", lat); end
    xact(16'hFFFF, 16'h0000, 1'b1, yv, cov, lat);
    checks++; if (yv !== 16'h0000 || cov !== 1'b1) begin errors++; $display("FAIL exact_wrap: got %b_%h want 1_0000", cov, yv); end
`ifdef FBA_ERR_MON_EN
    checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL exact_err_cnt: got %0d want 0", err_cnt); end
`endif
  endtask

  task automatic test_bounding();
    logic [W-1:0] yv; logic cov; int lat;
    cfg_set(4'd8);
`ifdef FBA_ERR_MON_EN
    mon_clear();
`endif
    xact(16'h00FF, 16'h0001, 1'b0, yv, cov, lat);
    checks++; if (yv !== 16'h00FF || cov !== 1'b0) begin errors++; $display("FAIL bound_y: got %b_%h want 0_00ff", cov, yv); end
`ifdef FBA_ERR_MON_EN
    checks++; if (err_cnt !== 32'd1 || err_acc !== 32'd1) begin errors++; $display("FAIL bound_mon: cnt %0d acc %0d want 1 1", err_cnt, err_acc); end
`endif
    xact(16'h00FF, 16'h0001, 1'b1, yv, cov, lat);
    checks++; if (yv !== 16'h00FF || cov !== 1'b0) begin errors++; $display("FAIL bound_cin_ignored: got %b_%h want 0_00ff", cov, yv); end
`ifdef FBA_ERR_MON_EN
    checks++; if (err_cnt !== 32'd2 || err_acc !== 32'd2) begin errors++; $display("FAIL bound_mon2: cnt %0d acc %0d want 2 2", err_cnt, err_acc); end
`endif
  endtask

  task automatic test_boundary();
    logic [W-1:0] yv; logic cov; int lat;
`ifdef FBA_ERR_MON_EN
    mon_clear();
`endif
    xact(16'hFFFF, 16'h0001, 1'b0, yv, cov, lat);
    checks++; if (yv !== 16'hFFFF || cov !== 1'b0) begin errors++; $display("FAIL bnd_ffff: got %b_%h want 0_ffff", cov, yv); end
`ifdef FBA_ERR_MON_EN
    checks++; if (err_cnt !== 32'd1 || err_acc !== 32'd1) begin errors++; $display("FAIL bnd_ffff_mon: cnt %0d acc %0d want 1 1", err_cnt, err_acc); end
`endif
    xact(16'h8000, 16'h8000, 1'b0, yv, cov, lat);
    checks++; if (yv !== 16'h0000 || cov !== 1'b1) begin errors++; $display("FAIL bnd_8000: got %b_%h want 1_0000", cov, yv); end
`ifdef FBA_ERR_MON_EN
    checks++; if (err_cnt !== 32'd1 || err_acc !== 32'd1) begin errors++; $display("FAIL bnd_8000_mon: cnt %0d acc %0d want 1 1", err_cnt, err_acc); end
`endif
  endtask

  task automatic test_fill();
    logic [W-1:0] yv; logic cov; int lat;
    cfg_set(4'd4);
`ifdef FBA_ERR_MON_EN
    mon_clear();
`endif
    xact(16'h0135, 16'h0246, 1'b0, yv, cov, lat);
    checks++; if (yv !== 16'h0377 || cov !== 1'b0) begin errors++; $display("FAIL fill_k4: got %b_%h want 0_0377", cov, yv); end
`ifdef FBA_ERR_MON_EN
    checks++; if (err_acc !== 32'd4) begin errors++; $display("FAIL fill_k4_acc: got %0d want 4", err_acc); end
`endif
    xact(16'h000A, 16'h0005, 1'b0, yv, cov, lat);
    checks++; if (yv !== 16'h000F) begin errors++; $display("FAIL or_k4: got %h want 000f", yv); end
    cfg_set(4'd3);
    xact(16'hFFFF, 16'h0008, 1'b0, yv, cov, lat);
    checks++; if (yv !== 16'h0007 || cov !== 1'b1) begin errors++; $display("FAIL hi_carry_k3: got %b_%h want 1_0007", cov, yv); end
    cfg_set(4'd8);
    xact(16'h12C3, 16'h3481, 1'b0, yv, cov, lat);
    checks++; if (yv !== 16'h46FF || cov !== 1'b0) begin errors++; $display("FAIL fill_k8: got %b_%h want 0_46ff", cov, yv); end
  endtask

  task automatic test_cfg_sat();
    cfg_set(4'd12);
    checks++; if (cfg_k_q !== 4'd8) begin errors++; $display("FAIL cfg_sat12: got %0d want 8", cfg_k_q); end
    cfg_set(4'd7);
    checks++; if (cfg_k_q !== 4'd7) begin errors++; $display("FAIL cfg_7: got %0d want 7", cfg_k_q); end
    cfg_set(4'd15);
    checks++; if (cfg_k_q !== 4'd8) begin errors++; $display("FAIL cfg_sat15: got %0d want 8", cfg_k_q); end
  endtask

  task automatic test_cfg_inflight();
    logic [W-1:0] ry[3];
    logic         rc[3];
    int got;
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cfg_we = 1'b0;
      in_valid = 1'b0;
      if (c == 0) begin
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
      end else if (c == 1) begin
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        cfg_we = 1'b1; cfg_k = 4'd0;
      end else if (c == 2) begin
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
      end
      #1;
      if (out_valid && got < 3) begin
        ry[got] = y; rc[got] = cout; got++;
      end
      @(negedge clk);
    end
    checks++; if (got !== 3) begin errors++; $display("FAIL inflight_count: got %0d want 3", got); end
    checks++; if (ry[0] !== 16'h00FF || rc[0] !== 1'b0) begin errors++; $display("FAIL inflight_item0: got %b_%h want 0_00ff", rc[0], ry[0]); end
    checks++; if (ry[1] !== 16'hFFFF || rc[1] !== 1'b0) begin errors++; $display("FAIL inflight_item1_oldk: got %b_%h want 0_ffff", rc[1], ry[1]); end
    checks++; if (ry[2] !== 16'h0100 || rc[2] !== 1'b0) begin errors++; $display("FAIL inflight_item2_newk: got %b_%h want 0_0100", rc[2], ry[2]); end
    checks++; if (cfg_k_q !== 4'd0) begin errors++; $display("FAIL inflight_cfg: got %0d want 0", cfg_k_q); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av[5];
    logic [W-1:0] ev[5];
    logic [W-1:0] res[5];
    logic [W-1:0] y0;
    logic seen, stable;
    int idx, got;
    for (int i = 0; i < 5; i++) begin
      av[i] = 16'h0101 * W'(i + 1);
      ev[i] = av[i] + 16'h0010;
    end
    out_ready = 1'b0;
    b = 16'h0010; cin = 1'b0;
    @(negedge clk);
    idx = 0; seen = 1'b0; stable = 1'b1; y0 = '0;
    for (int c = 0; c < 4; c++) begin
      a = av[idx]; in_valid = 1'b1;
      #1;
      if (out_valid) begin
        if (!seen) begin y0 = y; seen = 1'b1; end
        else if (y !== y0) stable = 1'b0;
      end
      if (in_ready) idx++;
      @(negedge clk);
    end
    #1;
    checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", idx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || y !== ev[0]) begin errors++; $display("FAIL bp_head: got %b_%h want 1_%h", out_valid, y, ev[0]); end
    checks++; if (stable !== 1'b1 || seen !== 1'b1) begin errors++; $display("FAIL bp_y_stable: got %b seen %b want 1 1", stable, seen); end
    out_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 30 && got < 5; n++) begin
      if (idx < 5) begin a = av[idx]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (out_valid) begin res[got] = y; got++; end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (got !== 5) begin errors++; $display("FAIL drain_count: got %0d want 5", got); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (res[i] !== ev[i]) begin errors++; $display("FAIL drain_order[%0d]: got %h want %h", i, res[i], ev[i]); end
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_no_dup: got %b want 0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    logic seen;
    cfg_set(4'd3);
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h3333;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_buffered: valid %b ready %b want 1 0", out_valid, in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
    checks++; if (cfg_k_q !== 4'd8) begin errors++; $display("FAIL mid_async_cfg: got %0d want 8", cfg_k_q); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_stale: stale result seen %b want 0", seen); end
    checks++; if (in_ready !== 1'b1 || cfg_k_q !== 4'd8) begin errors++; $display("FAIL mid_after: ready %b cfg %0d want 1 8", in_ready, cfg_k_q); end
`ifdef FBA_ERR_MON_EN
    checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL mid_mon: cnt %0d want 0", err_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_exact();
    test_bounding();
    test_boundary();
    test_fill();
    test_cfg_sat();
    cfg_set(4'd8);
    test_cfg_inflight();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fba_adder_pipe.md
Name: fba_adder_pipe

Overview:
- Parametrised, pipelined fixed-bounding approximate adder.
- The lower approximation field has a runtime-programmable width `k` (0..K); the upper bits use an exact adder.
- Two-stage valid/ready pipeline for use in CNN MAC datapaths.
- Optional error monitor compares each result against the exact sum, for accuracy characterisation.

Parameters:
- W, 16, operand/result width in bits (W >= 4)
- K, 8, maximum approximation width (1 <= K < W)
- KW, 4, width of the cfg_k field (2^KW > K)
- ACC_W, 32, width of the error accumulator (monitor only)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  load strobe for cfg_k
- cfg_k  in  KW  requested approximation width
- cfg_k_q  out  KW  active (saturated) approximation width
- in_valid  in  1  operand valid
- in_ready  out  1  operand accepted when in_valid & in_ready
- a  in  W  operand A
- b  in  W  operand B
- cin  in  1  carry in; used only when k = 0
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- y  out  W  sum
- cout  out  1  carry out of the upper adder
- err_clr  in  1  clear monitor counters (ERR_MON_EN only)
- err_cnt  out  32  number of inexact results (ERR_MON_EN only)
- err_acc  out  ACC_W  sum of |exact - approx| (ERR_MON_EN only)

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - Stage valids, out_valid, y, cout, err_cnt and err_acc go to 0.
  - cfg_k_q goes to K.
  - in_ready goes to 1 on the first clk after release.
- Configuration:
  - On cfg_we, cfg_k_q <= min(cfg_k, K).
  - The new value applies to operands accepted on later cycles.
  - Each transaction carries its own k through the pipe, so in-flight items are unaffected.
- Pipeline:
  - S1 registers a, b, cin and k. S2 computes and registers y, cout and the monitor error.
  - Latency: out_valid rises 2 cycles after acceptance.
  - Throughput: 1 result per cycle while out_ready = 1.
  - A stage loads when it is empty or its content is advancing.
  - in_ready = !s1_valid | (!s2_valid | out_ready); it is combinational from out_ready.
  - While out_valid & !out_ready, y and cout hold stable, and at most 2 items are buffered.
- Arithmetic, with lo = [k-1:0] and hi = [W-1:k]:
  - {cout, y[hi]} = a[hi] + b[hi], with no carry from the lo field.
  - Let i = highest index < k with a[i] & b[i].
  - If i exists: y[k-1:i+1] = a | b, and y[i:0] all ones.
  - If i does not exist: y[lo] = a[lo] | b[lo].
  - cin is ignored when k > 0.
  - When k = 0: {cout, y} = a + b + cin, which is exact.
- Simultaneous events:
  - cfg_we in the same cycle as an acceptance: that operand uses the old k.
  - err_clr in the same cycle as a result update: the clear wins and the result is not counted.
- Reset mid-operation drops all in-flight items. No output is produced for them.

Optional Feature:
- Macro: FBA_ERR_MON_EN.
- Defined:
  - S2 also computes exact = a + b + cin_eff (W+1 bits) and e = |exact - {cout, y}|.
  - On each result load: err_cnt += (e != 0), saturating at 2^32-1; err_acc += e, saturating at all ones.
  - err_clr zeroes both counters synchronously.
- Undefined: the err_clr, err_cnt and err_acc ports and their logic are absent; the datapath is unchanged.
- In both cases cin_eff = cin when k = 0, else 0.

Test Plan:
- Exact mode:
  - Stimulus: cfg_k = 0; a = 0x1234, b = 0x4321, cin = 1.
  - Response: y = 0x5556, cout = 0, out_valid exactly 2 cycles after acceptance, err_cnt unchanged.
- Bounding:
  - Stimulus: k = 8; a = 0x00FF, b = 0x0001.
  - Response: y = 0x00FF, cout = 0. Monitor: err_cnt = 1, err_acc = 1.
- Boundary:
  - Stimulus: k = 8; a = 0xFFFF, b = 0x0001.
  - Response: y = 0xFFFF, cout = 0, error = 1.
  - Then a = 0x8000, b = 0x8000 -> y = 0x0000, cout = 1, error = 0.
- Configuration saturation and ordering:
  - cfg_k = 12 with K = 8 -> cfg_k_q = 8.
  - cfg_we to k = 0 while 2 items are in flight: those items still use k = 8.
- Backpressure:
  - Stimulus: out_ready = 0 for 4 cycles with in_valid held at 1.
  - Response: exactly 2 items are accepted, then in_ready = 0; y is stable throughout.
  - On out_ready = 1: results drain in order with no loss or duplicate.
- Reset mid-stream:
  - Stimulus: drop rst_n with 2 items buffered.
  - Response: out_valid = 0 immediately, with no clock needed. After release, cfg_k_q = K and no stale result appears.
